// File: rtl/fpalu_pkg.sv
// Shared types and constants for the fpalu issue sequencer: FSM encoding, op codes, widths.
package fpalu_pkg;

  localparam int FP_WIDTH = 32;
  localparam int CNT_W    = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

endpackage

// File: rtl/fpalu_issue_stats.sv
// Saturating transfer and overflow counters for the issue sequencer.
// Counts one per completed output handshake; both counters stick at 16'hFFFF.
module fpalu_issue_stats (
  input  logic        clock,
  input  logic        reset,
  input  logic        xfer_vld,
  input  logic        xfer_ovf,
  output logic [15:0] stat_ops,
  output logic [15:0] stat_ovf
);

  logic [15:0] ops_q, ops_d;
  logic [15:0] ovf_q, ovf_d;

  always_comb begin
    ops_d = ops_q;
    ovf_d = ovf_q;
    if (xfer_vld && ops_q != 16'hFFFF) ops_d = ops_q + 16'd1;
    if (xfer_vld && xfer_ovf && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ops_q <= '0;
      ovf_q <= '0;
    end else begin
      ops_q <= ops_d;
      ovf_q <= ovf_d;
    end
  end

  assign stat_ops = ops_q;
  assign stat_ovf = ovf_q;

endmodule

// File: rtl/fpalu_issue_seq.sv
// Issue sequencer: holds operands stable SETTLE_CYCLES, captures result; out_valid SETTLE_CYCLES+1 edges after accept.
// One request in flight; result held until out_ready. FPALU_ISSUE_STATS_EN adds stat_ops/stat_ovf counters.
module fpalu_issue_seq
  import fpalu_pkg::*;
#(
  parameter int WIDTH         = FP_WIDTH,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_op,
  output logic             alu_reset_n,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_overflow,
  output logic             out_op
`ifdef FPALU_ISSUE_STATS_EN
  ,
  output logic [15:0]      stat_ops,
  output logic [15:0]      stat_ovf
`endif
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic               alu_op_q, alu_op_d;
  logic               alu_reset_n_q, alu_reset_n_d;
  logic [WIDTH-1:0]   out_result_q, out_result_d;
  logic               out_overflow_q, out_overflow_d;
  logic               out_op_q, out_op_d;
  logic               out_valid_q, out_valid_d;
  logic               accept;
  logic               capture;

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_SETTLE;
      ST_SETTLE:  if (cnt_q == '0) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_HOLD;
      ST_HOLD:    if (out_ready) state_d = in_valid ? ST_SETTLE : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // in_ready must not depend on in_valid, so it is decoded from state and out_ready only.
  always_comb begin
    in_ready = 1'b0;
    capture  = 1'b0;
    case (state_q)
      ST_IDLE:    in_ready = 1'b1;
      ST_HOLD:    in_ready = out_ready;
      ST_CAPTURE: capture  = 1'b1;
      default:    ;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_op_d       = alu_op_q;
    cnt_d          = cnt_q;
    out_result_d   = out_result_q;
    out_overflow_d = out_overflow_q;
    out_op_d       = out_op_q;
    out_valid_d    = out_valid_q;
    alu_reset_n_d  = ~reset;
    if (accept) begin
      alu_a_d  = in_a;
      alu_b_d  = in_b;
      alu_op_d = in_op;
      cnt_d    = CNT_LOAD;
    end else if (state_q == ST_SETTLE && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
    end
    if (capture) begin
      out_result_d   = alu_result;
      out_overflow_d = alu_overflow;
      out_op_d       = alu_op_q;
      out_valid_d    = 1'b1;
    end else if (state_q == ST_HOLD && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    alu_reset_n_q <= alu_reset_n_d;
    if (reset) begin
      cnt_q          <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= 1'b0;
      out_result_q   <= '0;
      out_overflow_q <= 1'b0;
      out_op_q       <= 1'b0;
      out_valid_q    <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_op_q       <= alu_op_d;
      out_result_q   <= out_result_d;
      out_overflow_q <= out_overflow_d;
      out_op_q       <= out_op_d;
      out_valid_q    <= out_valid_d;
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign alu_reset_n  = alu_reset_n_q;
  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_overflow = out_overflow_q;
  assign out_op       = out_op_q;

`ifdef FPALU_ISSUE_STATS_EN
  fpalu_issue_stats u_stats (
    .clock    (clock),
    .reset    (reset),
    .xfer_vld (out_valid_q & out_ready),
    .xfer_ovf (out_overflow_q),
    .stat_ops (stat_ops),
    .stat_ovf (stat_ovf)
  );
`endif

endmodule

// File: tb/tb_fpalu_issue_seq.sv
// Bench for fpalu_issue_seq: stand-in fpalu, request/response scoreboard, directed and random traffic.
module tb_fpalu_issue_seq;

  localparam int S = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_op;
  logic [31:0] in_a, in_b;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_op, alu_reset_n, alu_overflow;
  logic        out_valid, out_ready, out_overflow, out_op;
  logic [31:0] out_result;
`ifdef FPALU_ISSUE_STATS_EN
  logic [15:0] stat_ops, stat_ovf;
  int          exp_ops = 0;
  int          exp_ovf = 0;
`endif

  fpalu_issue_seq #(.WIDTH(32), .SETTLE_CYCLES(S)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_reset_n(alu_reset_n),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow), .out_op(out_op)
`ifdef FPALU_ISSUE_STATS_EN
    , .stat_ops(stat_ops), .stat_ovf(stat_ovf)
`endif
  );

  always #5 clock = ~clock;

  // Stand-in fpalu: exact IEEE answers for the known vectors, an arbitrary deterministic mix otherwise.
  function automatic logic [32:0] fp_model(input logic [31:0] a, input logic [31:0] b, input logic op);
    logic [32:0] s;
    if (a == 32'h3F800000 && b == 32'h40000000 && !op) return {1'b0, 32'h40400000};
    if (a == 32'h40000000 && b == 32'h40400000 &&  op) return {1'b0, 32'h40C00000};
    if (a == 32'h7F000000 && b == 32'h7F000000 &&  op) return {1'b1, 32'h7F800000};
    if (op) return {(({1'b0, a[30:23]} + {1'b0, b[30:23]}) > 9'd254), a ^ {b[7:0], b[31:8]}};
    s = {1'b0, a} + {1'b0, b};
    return s;
  endfunction

  always_comb {alu_overflow, alu_result} = fp_model(alu_a, alu_b, alu_op);

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_acc_cyc  = -1;
  int last_xfer_cyc = -2;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        op;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [64:0] alu_exp;
  logic        mon_ov, mon_rdy;
  logic [32:0] mon_r;

  always @(posedge clock) cyc = cyc + 1;

  // Scoreboard: an accepted request is due at the output S+2 negedges after the accept negedge.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      alu_exp = '0;
`ifdef FPALU_ISSUE_STATS_EN
      exp_ops = 0;
      exp_ovf = 0;
`endif
    end else begin
      mon_ov  = (exp_q.size() != 0) && (cyc >= exp_q[0].acc + S + 2);
      mon_rdy = (exp_q.size() == 0) || (mon_ov && out_ready);
      check("out_valid", 80'(out_valid), 80'(mon_ov));
      check("in_ready", 80'(in_ready), 80'(mon_rdy));
      check("alu_bus", 80'({alu_a, alu_b, alu_op}), 80'(alu_exp));
      if (mon_ov) begin
        check("out_result", 80'(out_result), 80'(exp_q[0].res));
        check("out_overflow", 80'(out_overflow), 80'(exp_q[0].ovf));
        check("out_op", 80'(out_op), 80'(exp_q[0].op));
        if (out_ready) begin
`ifdef FPALU_ISSUE_STATS_EN
          exp_ops++;
          if (exp_q[0].ovf) exp_ovf++;
`endif
          void'(exp_q.pop_front());
          last_xfer_cyc = cyc;
        end
      end
      if (in_valid && mon_rdy) begin
        mon_r = fp_model(in_a, in_b, in_op);
        exp_q.push_back(exp_t'{mon_r[31:0], mon_r[32], in_op, cyc});
        alu_exp = {in_a, in_b, in_op};
        last_acc_cyc = cyc;
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op);
    int n;
    n = 0;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    do begin
      @(negedge clock);
      n++;
    end while (!in_ready && n < 200);
    check("send_accept", 80'(in_ready), 80'(1'b1));
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!out_valid && n < 200);
    check("wait_valid", 80'(out_valid), 80'(1'b1));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain", 80'(exp_q.size()), 80'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, sent, guard;
    logic acc_now;
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; out_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_alu_bus", 80'({alu_a, alu_b, alu_op}), 80'(0));
    check("rst_out", 80'({out_valid, out_result, out_overflow, out_op}), 80'(0));
    check("rst_in_ready", 80'(in_ready), 80'(1'b1));
    check("rst_alu_reset_n", 80'(alu_reset_n), 80'(1'b0));
`ifdef FPALU_ISSUE_STATS_EN
    check("rst_stats", 80'({stat_ops, stat_ovf}), 80'(0));
`endif
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("alu_reset_n_lo", 80'(alu_reset_n), 80'(1'b0));
    @(negedge clock);
    check("alu_reset_n_hi", 80'(alu_reset_n), 80'(1'b1));
    @(posedge clock); #1;

    // Add
    send(32'h3F800000, 32'h40000000, 1'b0);
    wait_valid();
    check("add_result", 80'({out_result, out_overflow, out_op}), 80'({32'h40400000, 1'b0, 1'b0}));
    @(posedge clock); #1;
    wait_drain();

    // Multiply
    send(32'h40000000, 32'h40400000, 1'b1);
    wait_valid();
    check("mul_result", 80'({out_result, out_overflow, out_op}), 80'({32'h40C00000, 1'b0, 1'b1}));
    @(posedge clock); #1;
    wait_drain();

    // Overflow with backpressure; a waiting request must be ignored while held
    out_ready = 1'b0;
    send(32'h7F000000, 32'h7F000000, 1'b1);
    wait_valid();
    check("ovf_result", 80'({out_result, out_overflow, out_op}), 80'({32'h7F800000, 1'b1, 1'b1}));
    @(posedge clock); #1;
    in_a = 32'h3F800000; in_b = 32'h40000000; in_op = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("hold_state", 80'({out_valid, in_ready, out_result, out_overflow, out_op}),
            80'({1'b1, 1'b0, 32'h7F800000, 1'b1, 1'b1}));
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    send(32'h3F800000, 32'h40000000, 1'b0);
    wait_drain();

    // Back-to-back: second request waits through SETTLE and is taken on the drain edge
    send(32'h3F800000, 32'h40000000, 1'b0);
    a1 = last_acc_cyc;
    send(32'h40000000, 32'h40400000, 1'b1);
    check("b2b_drain_edge", 80'(last_acc_cyc), 80'(last_xfer_cyc));
    check("b2b_period", 80'(last_acc_cyc - a1), 80'(S + 2));
    wait_drain();
`ifdef FPALU_ISSUE_STATS_EN
    check("stat_ops", 80'(stat_ops), 80'(exp_ops));
    check("stat_ovf", 80'(stat_ovf), 80'(exp_ovf));
`endif

    // Reset during SETTLE discards the request silently
    send(32'h40000000, 32'h40400000, 1'b1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < S + 4; i++) begin
      @(negedge clock);
      check("no_pulse", 80'(out_valid), 80'(1'b0));
    end
    check("idle_after_rst", 80'(in_ready), 80'(1'b1));
`ifdef FPALU_ISSUE_STATS_EN
    check("stat_ops_rst", 80'(stat_ops), 80'(0));
`endif
    @(posedge clock); #1;

    // Random traffic with random consumer backpressure
    sent = 0; guard = 0;
    while ((sent < 60 || exp_q.size() != 0 || in_valid) && guard < 3000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && sent < 60 && $urandom_range(0, 1) == 1) begin
        in_a = $urandom; in_b = $urandom; in_op = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) begin in_a = 32'h7F000000; in_b = 32'h7F000000; in_op = 1'b1; end
        in_valid = 1'b1;
      end
      @(negedge clock);
      acc_now = in_valid && in_ready;
      @(posedge clock); #1;
      if (acc_now) begin
        in_valid = 1'b0;
        sent++;
      end
      guard++;
    end
    check("random_done", 80'(guard < 3000), 80'(1'b1));
`ifdef FPALU_ISSUE_STATS_EN
    check("stat_ops_end", 80'(stat_ops), 80'(exp_ops));
    check("stat_ovf_end", 80'(stat_ovf), 80'(exp_ovf));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
